phy_hard_reset_tx: RTL and testbench
====================================

Name: phy_hard_reset_tx

Overview:
Downstream stage of the TCPC reset block that turns its Hard Reset request into signalling on the PHY.
- Emits preamble symbols, then the Hard Reset ordered set, as 5-bit 4b5b symbols to the BMC line encoder over a valid/ready handshake.
- Reports completion with PHY_ACK, or abandonment with PHY_Stop_Attempting_Reset; both feed back into the reset block.

Parameters:
PREAMBLE_SYMS, 13, number of preamble symbol beats sent before the ordered set (13 x 5 = 65 bit times).
BUSY_TIMEOUT, 16, cycles to wait for CC_BUSY to deassert before abandoning the attempt.
CNT_W, 5, width of the beat/timeout counter; must hold max(PREAMBLE_SYMS, BUSY_TIMEOUT).

Ports:
CLK  input  1  system clock; single clock domain.
reset  input  1  synchronous, active-high reset.
HR_REQ  input  1  one-cycle Hard Reset request pulse from the reset block.
CC_BUSY  input  1  CC line occupied by another transmitter.
TX_READY  input  1  line encoder accepts TX_SYMBOL this cycle.
TX_SYMBOL  output  5  4b5b symbol to the line encoder.
TX_VALID  output  1  TX_SYMBOL valid.
TX_PREAMBLE  output  1  current beat is preamble; encoder sends raw alternating bits.
PHY_ACK  output  1  one-cycle pulse: ordered set fully accepted by the encoder.
PHY_Stop_Attempting_Reset  output  1  one-cycle pulse: attempt abandoned on busy timeout.
BUSY  output  1  high in every state except IDLE.

Behaviour:
- Reset values: all outputs 0; state IDLE; counter 0; pending latch 0.
- Reset asserted mid-operation: next edge returns to IDLE and drops TX_VALID immediately; no PHY_ACK or stop pulse is issued.
- Handshake: a beat transfers when TX_VALID && TX_READY on a rising edge. While TX_VALID && !TX_READY, TX_SYMBOL and TX_PREAMBLE hold stable. Counters advance only on transfer.
- States:
  - IDLE: HR_REQ -> WAIT_LINE, counter cleared.
  - WAIT_LINE: if !CC_BUSY -> PREAMBLE, counter cleared. Otherwise increment counter; when counter == BUSY_TIMEOUT-1 while CC_BUSY -> ABORT.
  - PREAMBLE: TX_VALID=1, TX_PREAMBLE=1, TX_SYMBOL=5'b10101. After PREAMBLE_SYMS transfers -> OSET, index 0.
  - OSET: TX_PREAMBLE=0. Symbols by index: 0..2 = RST-1 5'b00111, 3 = RST-2 5'b11001. Transfer at index 3 -> DONE.
  - DONE: PHY_ACK=1 for exactly one cycle, TX_VALID=0 -> IDLE.
  - ABORT: PHY_Stop_Attempting_Reset=1 for one cycle -> IDLE.
- CC_BUSY is sampled only in WAIT_LINE; once PREAMBLE starts, transmission is never interrupted.
- HR_REQ arriving in any non-IDLE state sets a one-deep pending latch. On return to IDLE with the latch set, go straight to WAIT_LINE and clear the latch. Further requests while pending are merged.
- HR_REQ in the same cycle as the DONE/ABORT exit sets the pending latch.
- Latency, no stall, line free: HR_REQ at cycle 0 -> first preamble beat valid at cycle 2 -> PHY_ACK at cycle 2+PREAMBLE_SYMS+4.

Optional Feature:
CABLE_RESET_EN:
- Defined: adds input CR_REQ (1-bit pulse). It follows the same flow but sends the Cable Reset ordered set RST-1 5'b00111, SYNC-1 5'b11000, RST-1 5'b00111, SYNC-3 5'b00110. A kind flag is latched at acceptance. HR_REQ and CR_REQ in the same cycle: HR wins and CR is dropped. The pending latch records kind, with HR priority.
- Undefined: no CR_REQ port; only Hard Reset is generated.

Decomposition:
- Shared package phy_pd_pkg: 4b5b K-code constants (RST1, RST2, SYNC1, SYNC3, PREAMBLE_SYM) and the state enum encoding.
- One natural sub-module, phy_oset_rom: combinational map of (kind, index[1:0]) to symbol. Everything else stays in the top.

Test Plan:
1. HR_REQ pulse, CC_BUSY=0, TX_READY=1 -> 13 preamble beats, then 00111, 00111, 00111, 11001; PHY_ACK at cycle 19; no stop pulse.
2. TX_READY toggling 1,0,0,1 during OSET -> TX_SYMBOL held through stalls; exactly 4 ordered-set transfers; PHY_ACK one cycle after the 4th transfer.
3. CC_BUSY held high for 20 cycles after HR_REQ -> PHY_Stop_Attempting_Reset pulse at cycle 17; TX_VALID never asserted.
4. CC_BUSY high for 5 cycles then low -> preamble starts the cycle after the drop; PHY_ACK issued.
5. Second HR_REQ during PREAMBLE -> after PHY_ACK, a second complete sequence runs back-to-back; a third request during it also completes.
6. reset asserted at OSET index 2 -> TX_VALID=0 next cycle; no PHY_ACK; a new HR_REQ afterwards produces a full normal sequence.

Source files
------------

// File: rtl/phy_pd_pkg.sv
// rtl/phy_pd_pkg.sv - shared 4b5b K-codes, FSM state encoding and reset-kind type
// Contents:
//   RST1, RST2, SYNC1, SYNC3, PREAMBLE_SYM : 5-bit 4b5b symbols
//   state_t : transmitter FSM states
//   kind_t  : which ordered set an attempt sends (Hard Reset or Cable Reset)
package phy_pd_pkg;

  localparam logic [4:0] RST1         = 5'b00111;
  localparam logic [4:0] RST2         = 5'b11001;
  localparam logic [4:0] SYNC1        = 5'b11000;
  localparam logic [4:0] SYNC3        = 5'b00110;
  localparam logic [4:0] PREAMBLE_SYM = 5'b10101;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_LINE = 3'd1,
    S_PREAMBLE  = 3'd2,
    S_OSET      = 3'd3,
    S_DONE      = 3'd4,
    S_ABORT     = 3'd5
  } state_t;

  typedef enum logic {
    KIND_HR = 1'b0,
    KIND_CR = 1'b1
  } kind_t;

endpackage

// File: rtl/phy_oset_rom.sv
// rtl/phy_oset_rom.sv - ordered-set symbol lookup by reset kind and symbol index
// Ports:
//   i_kind : KIND_HR selects Hard Reset, KIND_CR selects Cable Reset
//   i_idx  : symbol position within the 4-symbol ordered set
//   o_sym  : 4b5b symbol for that position
module phy_oset_rom
  import phy_pd_pkg::*;
(
  input  kind_t       i_kind,
  input  logic [1:0]  i_idx,
  output logic [4:0]  o_sym
);

  always_comb begin
    o_sym = RST1;
    if (i_kind == KIND_CR) begin
      case (i_idx)
        2'd0:    o_sym = RST1;
        2'd1:    o_sym = SYNC1;
        2'd2:    o_sym = RST1;
        default: o_sym = SYNC3;
      endcase
    end else begin
      o_sym = (i_idx == 2'd3) ? RST2 : RST1;
    end
  end

endmodule

// File: rtl/phy_hard_reset_tx.sv
// rtl/phy_hard_reset_tx.sv - turns a Hard Reset request into preamble + ordered-set symbols for the BMC encoder
// Optional feature macro: CABLE_RESET_EN (adds CR_REQ and the Cable Reset ordered set).
// Ports:
//   CLK, reset                : clock, synchronous active-high reset
//   HR_REQ                    : one-cycle Hard Reset request
//   CR_REQ                    : one-cycle Cable Reset request (CABLE_RESET_EN only)
//   CC_BUSY                   : CC line occupied, sampled only while waiting for the line
//   TX_READY                  : encoder accepts the current beat
//   TX_SYMBOL/TX_VALID        : symbol stream to the encoder
//   TX_PREAMBLE               : current beat is preamble
//   PHY_ACK                   : pulse, ordered set fully accepted
//   PHY_Stop_Attempting_Reset : pulse, attempt abandoned on busy timeout
//   BUSY                      : high whenever not idle
module phy_hard_reset_tx
  import phy_pd_pkg::*;
#(
  parameter int PREAMBLE_SYMS = 13,
  parameter int BUSY_TIMEOUT  = 16,
  parameter int CNT_W         = 5
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic       HR_REQ,
`ifdef CABLE_RESET_EN
  input  logic       CR_REQ,
`endif
  input  logic       CC_BUSY,
  input  logic       TX_READY,
  output logic [4:0] TX_SYMBOL,
  output logic       TX_VALID,
  output logic       TX_PREAMBLE,
  output logic       PHY_ACK,
  output logic       PHY_Stop_Attempting_Reset,
  output logic       BUSY
);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_pend;
  kind_t            r_pend_kind;
  kind_t            r_kind;

  logic             w_cr_req;
  logic             w_req_any;
  kind_t            w_req_kind;
  logic [1:0]       w_rom_idx;
  logic [4:0]       w_rom_sym;

`ifdef CABLE_RESET_EN
  assign w_cr_req = CR_REQ;
`else
  assign w_cr_req = 1'b0;
`endif

  // Hard Reset wins when both requests arrive together.
  assign w_req_any  = HR_REQ | w_cr_req;
  assign w_req_kind = HR_REQ ? KIND_HR : KIND_CR;

  // The ROM is addressed with the index of the symbol to present next, so the
  // registered TX_SYMBOL is loaded in the same edge that consumes the current one.
  assign w_rom_idx = (r_state == S_OSET) ? (r_cnt[1:0] + 2'd1) : 2'd0;

  phy_oset_rom u_rom (
    .i_kind (r_kind),
    .i_idx  (w_rom_idx),
    .o_sym  (w_rom_sym)
  );

  always_ff @(posedge CLK) begin
    if (reset) begin
      r_state                   <= S_IDLE;
      r_cnt                     <= '0;
      r_pend                    <= 1'b0;
      r_pend_kind               <= KIND_HR;
      r_kind                    <= KIND_HR;
      TX_SYMBOL                 <= 5'd0;
      TX_VALID                  <= 1'b0;
      TX_PREAMBLE               <= 1'b0;
      PHY_ACK                   <= 1'b0;
      PHY_Stop_Attempting_Reset <= 1'b0;
      BUSY                      <= 1'b0;
    end else begin
      PHY_ACK                   <= 1'b0;
      PHY_Stop_Attempting_Reset <= 1'b0;

      // One-deep pending latch; a Hard Reset upgrades a pending Cable Reset.
      if (r_state != S_IDLE && w_req_any) begin
        r_pend <= 1'b1;
        if (HR_REQ)
          r_pend_kind <= KIND_HR;
        else if (!r_pend)
          r_pend_kind <= KIND_CR;
      end

      case (r_state)
        S_IDLE: begin
          if (r_pend || w_req_any) begin
            r_state <= S_WAIT_LINE;
            r_cnt   <= '0;
            BUSY    <= 1'b1;
            r_pend  <= 1'b0;
            // A fresh request alongside a pending one is merged into it.
            if (r_pend)
              r_kind <= (HR_REQ) ? KIND_HR : r_pend_kind;
            else
              r_kind <= w_req_kind;
          end
        end

        S_WAIT_LINE: begin
          if (!CC_BUSY) begin
            r_state     <= S_PREAMBLE;
            r_cnt       <= '0;
            TX_VALID    <= 1'b1;
            TX_PREAMBLE <= 1'b1;
            TX_SYMBOL   <= PREAMBLE_SYM;
          end else if (r_cnt == CNT_W'(BUSY_TIMEOUT - 1)) begin
            r_state                   <= S_ABORT;
            PHY_Stop_Attempting_Reset <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        S_PREAMBLE: begin
          if (TX_READY) begin
            if (r_cnt == CNT_W'(PREAMBLE_SYMS - 1)) begin
              r_state     <= S_OSET;
              r_cnt       <= '0;
              TX_PREAMBLE <= 1'b0;
              TX_SYMBOL   <= w_rom_sym;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
        end

        S_OSET: begin
          if (TX_READY) begin
            if (r_cnt == CNT_W'(3)) begin
              r_state   <= S_DONE;
              r_cnt     <= '0;
              TX_VALID  <= 1'b0;
              TX_SYMBOL <= 5'd0;
              PHY_ACK   <= 1'b1;
            end else begin
              r_cnt     <= r_cnt + CNT_W'(1);
              TX_SYMBOL <= w_rom_sym;
            end
          end
        end

        S_DONE, S_ABORT: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
          BUSY    <= 1'b0;
        end

        default: begin
          r_state  <= S_IDLE;
          r_cnt    <= '0;
          TX_VALID <= 1'b0;
          BUSY     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_phy_hard_reset_tx.sv
// tb/tb_phy_hard_reset_tx.sv - self-checking bench for phy_hard_reset_tx
module tb_phy_hard_reset_tx;

  localparam int PRE = 13;
  localparam int TMO = 16;

  logic       CLK = 1'b0;
  logic       reset = 1'b1;
  logic       HR_REQ = 1'b0;
`ifdef CABLE_RESET_EN
  logic       CR_REQ = 1'b0;
`endif
  logic       CC_BUSY = 1'b0;
  logic       TX_READY = 1'b1;
  logic [4:0] TX_SYMBOL;
  logic       TX_VALID;
  logic       TX_PREAMBLE;
  logic       PHY_ACK;
  logic       PHY_Stop_Attempting_Reset;
  logic       BUSY;

  phy_hard_reset_tx dut (
    .CLK                       (CLK),
    .reset                     (reset),
    .HR_REQ                    (HR_REQ),
`ifdef CABLE_RESET_EN
    .CR_REQ                    (CR_REQ),
`endif
    .CC_BUSY                   (CC_BUSY),
    .TX_READY                  (TX_READY),
    .TX_SYMBOL                 (TX_SYMBOL),
    .TX_VALID                  (TX_VALID),
    .TX_PREAMBLE               (TX_PREAMBLE),
    .PHY_ACK                   (PHY_ACK),
    .PHY_Stop_Attempting_Reset (PHY_Stop_Attempting_Reset),
    .BUSY                      (BUSY)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
  endtask

  // Beat b of an attempt: preamble first, then the Hard Reset ordered set.
  function automatic logic [4:0] exp_sym(input int b);
    if (b < PRE) return 5'b10101;
    if (b - PRE < 3) return 5'b00111;
    return 5'b11001;
  endfunction

  // Behavioural model: what each cycle's outputs must be, from the request,
  // line-busy and ready inputs seen on the previous cycle.
  bit m_busy, m_waiting, m_sending, m_ack_due, m_stop_due, m_pend, done_now;
  int m_beat, m_wait;
  int ack_q[$];
  int stop_q[$];
  int valid_cycles = 0;

  always @(negedge CLK) begin
    if (cyc >= 1) begin
      chk("busy", BUSY, m_busy);
      chk("tx_valid", TX_VALID, m_sending);
      chk("phy_ack", PHY_ACK, m_ack_due);
      chk("stop_pulse", PHY_Stop_Attempting_Reset, m_stop_due);
      if (m_sending) begin
        chk("tx_symbol", TX_SYMBOL, exp_sym(m_beat));
        chk("tx_preamble", TX_PREAMBLE, m_beat < PRE);
      end
      if (PHY_ACK) ack_q.push_back(cyc);
      if (PHY_Stop_Attempting_Reset) stop_q.push_back(cyc);
      if (TX_VALID) valid_cycles++;

      if (reset) begin
        m_busy = 0; m_waiting = 0; m_sending = 0; m_ack_due = 0;
        m_stop_due = 0; m_pend = 0; m_beat = 0; m_wait = 0;
      end else begin
        done_now = m_ack_due || m_stop_due;
        m_ack_due = 0;
        m_stop_due = 0;
        if (HR_REQ && m_busy) m_pend = 1;
        if (done_now) begin
          m_busy = 0;
        end else if (!m_busy) begin
          if (m_pend || HR_REQ) begin
            m_busy = 1; m_waiting = 1; m_wait = 0; m_pend = 0;
          end
        end else if (m_waiting) begin
          if (!CC_BUSY) begin
            m_waiting = 0; m_sending = 1; m_beat = 0;
          end else if (m_wait == TMO - 1) begin
            m_waiting = 0; m_stop_due = 1;
          end else begin
            m_wait++;
          end
        end else if (m_sending && TX_READY) begin
          m_beat++;
          if (m_beat == PRE + 4) begin
            m_sending = 0; m_ack_due = 1;
          end
        end
      end
    end
  end

  function automatic int ack_at(input int i);
    return (ack_q.size() > i) ? ack_q[i] : -1;
  endfunction

  task automatic goto_cycle(input int c);
    while (cyc < c) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic pulse_hr(output int t);
    @(posedge CLK);
    #1;
    HR_REQ = 1'b1;
    t = cyc;
    @(posedge CLK);
    #1;
    HR_REQ = 1'b0;
  endtask

  task automatic wait_acks(input string name, input int n, input int budget);
    int i;
    i = 0;
    while (ack_q.size() < n && i < budget) begin
      @(posedge CLK);
      i++;
    end
    #1;
    chk(name, ack_q.size() >= n, 1);
  endtask

  initial begin
    int t0, na, ns, vc;
    logic [1:0] pat [4];
    pat[0] = 2'd1; pat[1] = 2'd0; pat[2] = 2'd0; pat[3] = 2'd1;

    repeat (3) @(posedge CLK);
    #1;
    reset = 1'b0;
    @(negedge CLK);
    chk("reset_tx_valid", TX_VALID, 0);
    chk("reset_tx_symbol", TX_SYMBOL, 0);
    chk("reset_busy", BUSY, 0);
    chk("reset_ack", PHY_ACK, 0);

    // 1: plain Hard Reset, line free, encoder always ready
    na = ack_q.size(); ns = stop_q.size();
    pulse_hr(t0);
    wait_acks("t1_ack_timeout", na + 1, 60);
    chk("t1_ack_latency", ack_at(na) - t0, 19);
    chk("t1_no_stop", stop_q.size() - ns, 0);
    repeat (3) @(posedge CLK);

    // 2: stalls 1,0,0,1 starting at ordered-set index 2
    na = ack_q.size();
    pulse_hr(t0);
    goto_cycle(t0 + 17);
    for (int i = 0; i < 4; i++) begin
      TX_READY = pat[i][0];
      @(posedge CLK);
      #1;
    end
    TX_READY = 1'b1;
    wait_acks("t2_ack_timeout", na + 1, 60);
    chk("t2_ack_latency", ack_at(na) - t0, 21);
    repeat (3) @(posedge CLK);

    // 3: line busy throughout -> abandon
    na = ack_q.size(); ns = stop_q.size(); vc = valid_cycles;
    #1;
    CC_BUSY = 1'b1;
    pulse_hr(t0);
    goto_cycle(t0 + 20);
    CC_BUSY = 1'b0;
    repeat (3) @(posedge CLK);
    chk("t3_stop_count", stop_q.size() - ns, 1);
    chk("t3_stop_cycle", (stop_q.size() > ns) ? stop_q[ns] - t0 : -1, 17);
    chk("t3_no_valid", valid_cycles - vc, 0);
    chk("t3_no_ack", ack_q.size() - na, 0);

    // 4: line busy for cycles 0..4 then free
    na = ack_q.size();
    CC_BUSY = 1'b1;
    pulse_hr(t0);
    goto_cycle(t0 + 5);
    CC_BUSY = 1'b0;
    wait_acks("t4_ack_timeout", na + 1, 60);
    chk("t4_ack_latency", ack_at(na) - t0, 23);
    repeat (3) @(posedge CLK);

    // 5: requests during preamble of the first and second attempts
    na = ack_q.size();
    pulse_hr(t0);
    goto_cycle(t0 + 5);
    HR_REQ = 1'b1; @(posedge CLK); #1; HR_REQ = 1'b0;
    goto_cycle(t0 + 25);
    HR_REQ = 1'b1; @(posedge CLK); #1; HR_REQ = 1'b0;
    wait_acks("t5_ack_timeout", na + 3, 120);
    chk("t5_ack1", ack_at(na) - t0, 19);
    chk("t5_ack2", ack_at(na + 1) - t0, 39);
    chk("t5_ack3", ack_at(na + 2) - t0, 59);
    repeat (3) @(posedge CLK);

    // 6: request in the same cycle as the PHY_ACK exit is kept pending
    na = ack_q.size();
    pulse_hr(t0);
    goto_cycle(t0 + 19);
    HR_REQ = 1'b1; @(posedge CLK); #1; HR_REQ = 1'b0;
    wait_acks("t6_ack_timeout", na + 2, 80);
    chk("t6_ack2", ack_at(na + 1) - t0, 39);
    repeat (3) @(posedge CLK);

    // 7: reset at ordered-set index 2, then a clean attempt
    na = ack_q.size();
    pulse_hr(t0);
    goto_cycle(t0 + 17);
    reset = 1'b1;
    @(posedge CLK);
    #1;
    reset = 1'b0;
    @(negedge CLK);
    chk("t7_valid_dropped", TX_VALID, 0);
    repeat (20) @(posedge CLK);
    chk("t7_no_ack", ack_q.size() - na, 0);
    pulse_hr(t0);
    wait_acks("t7_ack_timeout", na + 1, 60);
    chk("t7_ack_latency", ack_at(na) - t0, 19);
    repeat (3) @(posedge CLK);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

endmodule
